// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency data memory between
// the core LSU (port C) and the debug/DMA loader (port D); one response per grant.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_e;

    typedef enum logic {
        PORT_C,
        PORT_D
    } port_e;

    // Two extra bits so DEPTH_WORDS*4 never wraps, even when it equals 2**ADDR_W.
    localparam logic [ADDR_W+1:0] ADDR_LIMIT = (ADDR_W + 2)'(DEPTH_WORDS) << 2;

    state_e state_q, state_d;
    port_e  rr_q,    rr_d;
    port_e  owner_q, owner_d;
    logic   we_q,    we_d;
    logic   err_q,   err_d;

    port_e              win;
    logic               win_valid;
    logic               win_we;
    logic               win_err;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    always_comb begin
        win_valid = c_req | d_req;
        if (c_req && d_req) begin
            win = rr_q;
        end else if (c_req) begin
            win = PORT_C;
        end else begin
            win = PORT_D;
        end

        win_we    = (win == PORT_C) ? c_we    : d_we;
        win_addr  = (win == PORT_C) ? c_addr  : d_addr;
        win_wdata = (win == PORT_C) ? c_wdata : d_wdata;
        win_err   = (win_addr[1:0] != 2'b00) || ({2'b00, win_addr} >= ADDR_LIMIT);
    end

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        owner_d          = owner_q;
        we_d             = we_q;
        err_d            = err_q;
        c_gnt            = 1'b0;
        d_gnt            = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rst && win_valid) begin
                    c_gnt            = (win == PORT_C);
                    d_gnt            = (win == PORT_D);
                    mem_address      = win_addr;
                    mem_write_data   = win_wdata;
                    // Rejected transactions are still granted but never touch memory.
                    mem_write_enable = win_we  && !win_err;
                    mem_read_enable  = !win_we && !win_err;
                    state_d          = S_RESP;
                    owner_d          = win;
                    we_d             = win_we;
                    err_d            = win_err;
                    rr_d             = (win == PORT_C) ? PORT_D : PORT_C;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic resp_c;
    logic resp_d;
    logic resp_data_ok;

    always_comb begin
        resp_c       = (state_q == S_RESP) && (owner_q == PORT_C);
        resp_d       = (state_q == S_RESP) && (owner_q == PORT_D);
        resp_data_ok = !we_q && !err_q;

        c_rvalid = resp_c;
        d_rvalid = resp_d;
        c_err    = resp_c && err_q;
        d_err    = resp_d && err_q;
        c_rdata  = (resp_c && resp_data_ok) ? mem_read_data : '0;
        d_rdata  = (resp_d && resp_data_ok) ? mem_read_data : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= PORT_C;
            owner_q <= PORT_C;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

endmodule
